// File: rtl/idli_slice_alu.sv
// Slice-serial ALU/comparator: operands arrive LS slice first, result slices appear 1 cycle later,
// flag pulses with the last slice. No backpressure: one slice is accepted every cycle it is presented.
module idli_slice_alu #(
  parameter int SLICE_W    = 4,
  parameter int NUM_SLICES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [2:0]         i_op,
  input  logic [2:0]         i_cmp_op,
  input  logic [SLICE_W-1:0] i_lhs,
  input  logic [SLICE_W-1:0] i_rhs,
  output logic [SLICE_W-1:0] o_res,
  output logic               o_valid,
  output logic               o_last,
  output logic               o_flag,
  output logic               o_flag_valid
);

  localparam int CW = ($clog2(NUM_SLICES) < 1) ? 1 : $clog2(NUM_SLICES);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_SLICES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        cmp_q, cmp_d;
  logic              carry_q, carry_d;
  logic              fcarry_q, fcarry_d;
  logic              zero_q, zero_d;

  logic [SLICE_W-1:0] res_q;
  logic               valid_q, last_q, flag_q, fvld_q;

  logic               accept, is_last, is_sub, cin, fcin, zin;
  logic [2:0]         op_eff, cmp_eff;
  logic [CW-1:0]      idx;
  logic [SLICE_W-1:0] b_opnd, res;
  logic [SLICE_W:0]   sum, fsum;
  logic               fz, fn, fc, fv, flag;

  always_comb begin
    accept  = i_start | (state_q == BUSY);
    op_eff  = i_start ? i_op : op_q;
    cmp_eff = i_start ? i_cmp_op : cmp_q;
    idx     = i_start ? '0 : cnt_q;
    is_last = accept && (idx == LAST_IDX);
    is_sub  = (op_eff == 3'd4);

    // A start always seeds fresh chains, which is also what makes abort-restart clean.
    cin     = i_start ? is_sub : carry_q;
    fcin    = i_start ? 1'b1   : fcarry_q;
    zin     = i_start ? 1'b1   : zero_q;

    b_opnd  = is_sub ? ~i_rhs : i_rhs;
    sum     = {1'b0, i_lhs} + {1'b0, b_opnd} + {{SLICE_W{1'b0}}, cin};
    fsum    = {1'b0, i_lhs} + {1'b0, ~i_rhs} + {{SLICE_W{1'b0}}, fcin};

    fz = zin & (fsum[SLICE_W-1:0] == '0);
    fn = fsum[SLICE_W-1];
    fc = fsum[SLICE_W];
    fv = (i_lhs[SLICE_W-1] ^ i_rhs[SLICE_W-1]) & (i_lhs[SLICE_W-1] ^ fn);

    res = sum[SLICE_W-1:0];
    case (op_eff)
      3'd1:    res = i_lhs & i_rhs;
      3'd2:    res = i_lhs | i_rhs;
      3'd3:    res = i_lhs ^ i_rhs;
      default: res = sum[SLICE_W-1:0];
    endcase

    flag = 1'b1;
    case (cmp_eff)
      3'd0:    flag = fz;
      3'd1:    flag = ~fz;
      3'd2:    flag = fn ^ fv;
      3'd3:    flag = ~fc;
      3'd4:    flag = ~(fn ^ fv);
      3'd5:    flag = fc;
      default: flag = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    cmp_d    = cmp_q;
    carry_d  = carry_q;
    fcarry_d = fcarry_q;
    zero_d   = zero_q;
    if (accept) begin
      op_d     = op_eff;
      cmp_d    = cmp_eff;
      carry_d  = sum[SLICE_W];
      fcarry_d = fc;
      zero_d   = fz;
      if (is_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = BUSY;
        cnt_d   = idx + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      cmp_q    <= '0;
      carry_q  <= 1'b0;
      fcarry_q <= 1'b0;
      zero_q   <= 1'b0;
      res_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      flag_q   <= 1'b0;
      fvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      cmp_q    <= cmp_d;
      carry_q  <= carry_d;
      fcarry_q <= fcarry_d;
      zero_q   <= zero_d;
      valid_q  <= accept;
      last_q   <= is_last;
      fvld_q   <= is_last;
      if (accept)  res_q  <= res;
      if (is_last) flag_q <= flag;
    end
  end

  assign o_res        = res_q;
  assign o_valid      = valid_q;
  assign o_last       = last_q;
  assign o_flag       = flag_q;
  assign o_flag_valid = fvld_q;

endmodule

// File: doc/idli_slice_alu.md
# idli_slice_alu

Parametrised slice-serial ALU and comparator for the idli core. Consumes two operands least-significant slice first, one slice per cycle over `NUM_SLICES` cycles. Produces the result slice-by-slice one cycle later, plus a single-cycle condition flag at the end of each operation. Generalises the fixed 4b × 4-slice datapath to arbitrary slice width and count. Adds subtraction and full comparison (signed/unsigned) with carry and overflow tracking across slices.

## Interface
Parameters:
- `SLICE_W`, 4: bits per slice; ≥1.
- `NUM_SLICES`, 4: slices per operand; ≥2. Data width is `SLICE_W*NUM_SLICES`.

Ports:
- `i_clk`  in  1  core clock; single clock domain.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_start`  in  1  current slices are slice 0 of a new operation; samples `i_op` and `i_cmp_op`.
- `i_op`  in  3  0=ADD, 1=AND, 2=OR, 3=XOR, 4=SUB; 5–7 behave as ADD.
- `i_cmp_op`  in  3  0=EQ, 1=NE, 2=LT, 3=LTU, 4=GE, 5=GEU, 6=ANY, 7=ANY.
- `i_lhs`  in  SLICE_W  left operand slice.
- `i_rhs`  in  SLICE_W  right operand slice.
- `o_res`  out  SLICE_W  registered result slice.
- `o_valid`  out  1  `o_res` holds a valid slice.
- `o_last`  out  1  `o_res` is the final (most-significant) slice.
- `o_flag`  out  1  comparison outcome; meaningful when `o_flag_valid`.
- `o_flag_valid`  out  1  single-cycle pulse, coincident with `o_last`.

## Operation
- States: IDLE, BUSY. Slice counter is `max(1,$clog2(NUM_SLICES))` bits.
- IDLE: `i_start`=1 latches op and cmp_op, processes slice 0, sets counter=1, enters BUSY. Slices without `i_start` are ignored, and `o_valid` stays 0 on the next cycle.
- BUSY: processes one slice per cycle and increments the counter. After processing slice `NUM_SLICES-1`:
  - `i_start`=0 returns the block to IDLE.
  - `i_start`=1 on the next cycle starts a new operation with no bubble.
- `i_start` asserted while BUSY before the final slice aborts the current operation:
  - The new operation restarts at slice 0 with fresh carry, zero and op state.
  - The aborted operation never raises `o_last` or `o_flag_valid`.
- Arithmetic:
  - SUB uses `rhs` inverted with carry-in 1; ADD uses carry-in 0.
  - A carry register holds the carry-out of each slice and is the carry-in for the next.
  - Final carry-out is the data-width carry and is discarded from `o_res`.
- AND/OR/XOR are bitwise per slice; carry is unused.
- Flags always come from an internal subtract `lhs - rhs`, run in parallel with `i_op`, with its own carry chain:
  - Z: all subtract slices zero (sticky AND across slices).
  - C: final subtract carry-out; 1 means no borrow.
  - N: MSB of the final subtract slice.
  - V: `(lhs_msb ^ rhs_msb) & (lhs_msb ^ N)` on the final slice.
- Flag by cmp_op:
  - EQ=Z, NE=!Z.
  - LT=N^V, GE=!(N^V).
  - LTU=!C, GEU=C.
  - ANY=1.

## Timing
- Input slice k at cycle T+k produces `o_res` slice k valid at T+k+1 (latency 1, throughput one slice per cycle).
- `o_last`, `o_flag_valid` and `o_flag` assert at T+NUM_SLICES for exactly one cycle.
- Outputs when no slice is valid:
  - `o_valid`=0, `o_last`=0, `o_flag_valid`=0.
  - `o_res` and `o_flag` hold their previous values.
- Reset, including mid-operation, on the cycle after `i_rst`=1:
  - State=IDLE; all outputs 0.
  - Counter, carry and zero registers cleared.
  - `i_start` is ignored while `i_rst`=1.

## Test plan
- ADD 0x1234+0x0FFF (defaults) → `o_res` slices 3,3,2,2 over T+1..T+4 (0x2233); `o_last` at T+4 only.
- SUB 0x0000−0x0001, cmp LTU → result 0xFFFF; `o_flag`=1 and `o_flag_valid` at T+4. Same operands with GEU → `o_flag`=0.
- Signed compare, cmp LT, lhs=0x8000, rhs=0x0001 → `o_flag`=1. Swapped operands → 0. Operands 0x7FFF vs 0x8000 with GE → 1 (overflow path).
- Back-to-back EQ 0x5A5A/0x5A5A then NE 0x0001/0x0000 with `i_start` at T and T+4 → flags 1 at T+4 and 1 at T+8; `o_valid` continuous T+1..T+8.
- `i_start` again at T+2 → no `o_last` for the first operation; the second operation's result completes at T+6. Separately, `i_rst` at T+2 → all outputs 0 from T+3, IDLE.
- `SLICE_W`=8, `NUM_SLICES`=4: ADD 0xFFFFFFFF+0x00000001 → 0x00000000. cmp EQ on XOR of equal operands → result 0, `o_flag`=1.
